overlay_sequencer: RTL and testbench

Frame-rate scheduler for the text overlay stage. It decides which banners are enabled: the title banner, the TT08 banner and the SDA credits banner. It also drives the title's horizontal slide-in offset and the animated drop-shadow offset.
- Sits between the VGA timing generator (consumes `frame_start`) and the overlay/text renderers (which consume the enables and offsets combinationally).
- All outputs change only at frame boundaries, so every visible frame is glitch-free.

---
 rtl/overlay_sequencer.sv | 154 +++++++++++++++
 tb/tb_overlay_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/overlay_sequencer.sv
// Frame-rate scheduler for the text overlay: banner enables, title slide-in offset and drop-shadow animation.
// Build option: define OVERLAY_SEQ_LOOP_EN to loop CREDITS back to BLANK instead of parking in DONE.
module overlay_sequencer #(
    parameter int unsigned FRAMES_BLANK   = 60,
    parameter int unsigned FRAMES_TITLE   = 180,
    parameter int unsigned FRAMES_CREDITS = 240,
    parameter int unsigned SLIDE_STEP     = 8,
    parameter int unsigned SHADOW_MAX     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       run,
    input  logic       skip,
    output logic       title_en,
    output logic       tt08_en,
    output logic       sda_en,
    output logic [9:0] x_offset,
    output logic [2:0] shadow_dx,
    output logic [2:0] shadow_dy,
    output logic [2:0] seq_state
);

    localparam logic [2:0] S_BLANK   = 3'd0;
    localparam logic [2:0] S_SLIDE   = 3'd1;
    localparam logic [2:0] S_TITLE   = 3'd2;
    localparam logic [2:0] S_CREDITS = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [9:0] X_START      = 10'd640;
    localparam logic [9:0] STEP         = 10'(SLIDE_STEP);
    localparam logic [2:0] SH_MAX       = 3'(SHADOW_MAX);
    localparam logic [8:0] BLANK_LAST   = 9'(FRAMES_BLANK - 1);
    localparam logic [8:0] TITLE_LAST   = 9'(FRAMES_TITLE - 1);
    localparam logic [8:0] CREDITS_LAST = 9'(FRAMES_CREDITS - 1);

    logic [2:0] state, state_nxt;
    logic [8:0] cnt, cnt_nxt;
    logic [9:0] x_nxt;
    logic [2:0] shadow, shadow_nxt;
    logic       title_nxt, tt08_nxt, sda_nxt;
    logic       update;

    function automatic logic [2:0] shadow_sat(input logic [2:0] v);
        return (v < SH_MAX) ? v + 3'd1 : v;
    endfunction

    function automatic logic [9:0] slide_sat(input logic [9:0] v);
        return (v < STEP) ? 10'd0 : v - STEP;
    endfunction

    assign update    = frame_start & run;
    assign seq_state = state;
    assign shadow_dx = shadow;
    assign shadow_dy = shadow;

    // Everything, including the banner enables, is registered so renderers see whole-frame-stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BLANK;
            cnt      <= 9'd0;
            x_offset <= X_START;
            shadow   <= 3'd0;
            title_en <= 1'b0;
            tt08_en  <= 1'b0;
            sda_en   <= 1'b0;
        end else if (update) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            x_offset <= x_nxt;
            shadow   <= shadow_nxt;
            title_en <= title_nxt;
            tt08_en  <= tt08_nxt;
            sda_en   <= sda_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        x_nxt      = x_offset;
        shadow_nxt = shadow;
        case (state)
            S_BLANK: begin
                x_nxt      = X_START;
                shadow_nxt = 3'd0;
                if (skip || cnt == BLANK_LAST) begin
                    state_nxt = S_SLIDE;
                    cnt_nxt   = 9'd0;
                end else begin
                    cnt_nxt = cnt + 9'd1;
                end
            end
            S_SLIDE: begin
                cnt_nxt = 9'd0;
                x_nxt   = skip ? 10'd0 : slide_sat(x_offset);
                if (x_nxt == 10'd0) begin
                    state_nxt = S_TITLE;
                end
            end
            S_TITLE: begin
                x_nxt      = 10'd0;
                shadow_nxt = shadow_sat(shadow);
                if (skip || cnt == TITLE_LAST) begin
                    state_nxt = S_CREDITS;
                    cnt_nxt   = 9'd0;
                end else begin
                    cnt_nxt = cnt + 9'd1;
                end
            end
            S_CREDITS: begin
                shadow_nxt = shadow_sat(shadow);
                if (skip || cnt == CREDITS_LAST) begin
                    cnt_nxt = 9'd0;
`ifdef OVERLAY_SEQ_LOOP_EN
                    state_nxt  = S_BLANK;
                    shadow_nxt = 3'd0;
                    x_nxt      = X_START;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    cnt_nxt = cnt + 9'd1;
                end
            end
            S_DONE: begin
                shadow_nxt = shadow_sat(shadow);
            end
            default: begin
                state_nxt  = S_BLANK;
                cnt_nxt    = 9'd0;
                x_nxt      = X_START;
                shadow_nxt = 3'd0;
            end
        endcase
    end

    // Enables decode the state being entered so they land in the same update as the transition.
    always_comb begin
        title_nxt = 1'b0;
        tt08_nxt  = 1'b0;
        sda_nxt   = 1'b0;
        case (state_nxt)
            S_SLIDE, S_TITLE: title_nxt = 1'b1;
            S_CREDITS, S_DONE: begin
                title_nxt = 1'b1;
                tt08_nxt  = 1'b1;
                sda_nxt   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_overlay_sequencer.sv
// Scoreboard bench for overlay_sequencer: directed sequence walk, freeze/skip, async reset, then random stimulus.
module tb_overlay_sequencer;

    localparam int FB   = 2;
    localparam int FT   = 3;
    localparam int FC   = 2;
    localparam int STEP = 200;
    localparam int SMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       run = 1'b1;
    logic       skip = 1'b0;
    logic       title_en, tt08_en, sda_en;
    logic [9:0] x_offset;
    logic [2:0] shadow_dx, shadow_dy, seq_state;

    overlay_sequencer #(
        .FRAMES_BLANK(FB), .FRAMES_TITLE(FT), .FRAMES_CREDITS(FC),
        .SLIDE_STEP(STEP), .SHADOW_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .run(run), .skip(skip),
        .title_en(title_en), .tt08_en(tt08_en), .sda_en(sda_en), .x_offset(x_offset),
        .shadow_dx(shadow_dx), .shadow_dy(shadow_dy), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       t;
        logic       tt;
        logic       sd;
        logic [9:0] x;
        logic [2:0] dx;
        logic [2:0] dy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase, frames spent in phase, frames since the title appeared.
    int m_phase, m_n, m_tn;

    function automatic void model_reset();
        m_phase = 0;
        m_n     = 0;
        m_tn    = 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   xv;
        e.st = 3'(m_phase);
        e.t  = (m_phase != 0);
        e.tt = (m_phase >= 3);
        e.sd = (m_phase >= 3);
        if (m_phase == 0) xv = 640;
        else if (m_phase == 1) begin
            xv = 640 - STEP * m_n;
            if (xv < 0) xv = 0;
        end else xv = 0;
        e.x  = 10'(xv);
        e.dx = (m_phase >= 2) ? 3'((m_tn < SMAX) ? m_tn : SMAX) : 3'd0;
        e.dy = e.dx;
        return e;
    endfunction

    function automatic void model_step(input logic sk);
        m_n++;
        case (m_phase)
            0: if (sk || m_n == FB) begin m_phase = 1; m_n = 0; end
            1: if (sk || 640 - STEP * m_n <= 0) begin m_phase = 2; m_n = 0; m_tn = 0; end
            2: begin
                m_tn++;
                if (sk || m_n == FT) begin m_phase = 3; m_n = 0; end
            end
            3: begin
                m_tn++;
                if (sk || m_n == FC) begin
`ifdef OVERLAY_SEQ_LOOP_EN
                    m_phase = 0;
`else
                    m_phase = 4;
`endif
                    m_n = 0;
                end
            end
            default: m_tn++;
        endcase
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a.st = seq_state;
        a.t  = title_en;
        a.tt = tt08_en;
        a.sd = sda_en;
        a.x  = x_offset;
        a.dx = shadow_dx;
        a.dy = shadow_dy;
        return a;
    endfunction

    task automatic compare(input exp_t e, input string tag);
        exp_t a;
        a = dut_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got st=%0d en=%b%b%b x=%0d dx=%0d dy=%0d, expected st=%0d en=%b%b%b x=%0d dx=%0d dy=%0d",
                     tag, $time, a.st, a.t, a.tt, a.sd, a.x, a.dx, a.dy,
                     e.st, e.t, e.tt, e.sd, e.x, e.dx, e.dy);
        end
    endtask

    // Monitor: every frame_start seen at a clock edge yields one output to check 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            if (frame_start && rst_n) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow @%0t: got output with no expectation, expected queued entry", $time);
                end else begin
                    compare(exp_q.pop_front(), "frame_update");
                end
            end
        end
    end

    task automatic drive(input logic fs, input logic r, input logic sk);
        @(negedge clk);
        frame_start = fs;
        run         = r;
        skip        = sk;
        if (fs) begin
            if (r) model_step(sk);
            exp_q.push_back(model_out());
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic mid_reset(input string tag);
        drive(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        compare(model_out(), tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare(model_out(), "reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare(model_out(), "blank_idle");

        // Full walk: BLANK(2) -> SLIDE(4) -> TITLE(3) -> CREDITS(2) -> end action, then 10 more.
        pulses(2);
        pulses(4);
        pulses(3);
        pulses(2);
        pulses(10);

        // Skip from BLANK, one slide step, skip to TITLE, then freeze in TITLE.
        mid_reset("reset_before_skip");
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        pulses(3);
        pulses(1);
        mid_reset("async_reset_in_credits");

        // Random frame_start / run / skip with periodic mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 19) == 0));
            if (i % 250 == 249) mid_reset("async_reset_random");
        end
        drive(1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
